// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a multi-digit common-anode 7-segment display.
// The value is loaded into a pending register and moved to the shadow register only at a frame boundary, so a frame never tears.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int P_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  lzb_en,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick,
    output logic                  pending
);

    logic [P_W-1:0]      r_p;
    logic [IDX_W-1:0]    r_digit_idx;
    logic                r_frame_tick;
    logic [4*DIGITS-1:0] r_pend_val;
    logic [DIGITS-1:0]   r_pend_dp;
    logic                r_pending;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;

    logic                w_wrap;
    logic                w_frame;
    logic [3:0]          w_nibble;
    logic [DIGITS-1:0]   w_zero_from;
    logic                w_lzb;
    logic [6:0]          w_seg_on;
    logic                w_dp_on;
    logic [DIGITS-1:0]   w_an_on;

    function automatic logic [6:0] f_decode(input logic [3:0] nib, input logic hex);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            default: pat = 7'h71;
        endcase
        if (!hex && nib > 4'd9) pat = 7'h00;
        return pat;
    endfunction

    assign w_wrap  = (r_p == P_W'(REFRESH_DIV - 1));
    assign w_frame = w_wrap && (r_digit_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p          <= '0;
            r_digit_idx  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame;
            if (w_wrap) begin
                r_p         <= '0;
                r_digit_idx <= (r_digit_idx == IDX_W'(DIGITS - 1)) ? '0 : r_digit_idx + IDX_W'(1);
            end else begin
                r_p <= r_p + P_W'(1);
            end
        end
    end

    // A load on the boundary cycle still moves the old pending data to shadow; the new data stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pending    <= 1'b0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
        end else begin
            if (w_frame && r_pending) begin
                r_shadow_val <= r_pend_val;
                r_shadow_dp  <= r_pend_dp;
            end
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
                r_pending  <= 1'b1;
            end else if (w_frame) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        logic v_acc;
        v_acc       = 1'b1;
        w_zero_from = '0;
        w_an_on     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_acc          = v_acc && (r_shadow_val[4*i +: 4] == 4'h0);
            w_zero_from[i] = v_acc;
        end
        w_nibble = r_shadow_val[{r_digit_idx, 2'b00} +: 4];
        w_lzb    = lzb_en && (r_digit_idx != '0) && w_zero_from[r_digit_idx];
        w_seg_on = (blank || w_lzb) ? 7'h00 : f_decode(w_nibble, hex_mode);
        w_dp_on  = !blank && r_shadow_dp[r_digit_idx];
        if (r_p >= P_W'(GUARD)) w_an_on[r_digit_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= {7{SEG_ACTIVE_LOW}};
            r_dp  <= SEG_ACTIVE_LOW;
            r_an  <= {DIGITS{AN_ACTIVE_LOW}};
        end else begin
            r_seg <= w_seg_on ^ {7{SEG_ACTIVE_LOW}};
            r_dp  <= w_dp_on ^ SEG_ACTIVE_LOW;
            r_an  <= w_an_on ^ {DIGITS{AN_ACTIVE_LOW}};
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign digit_idx  = r_digit_idx;
    assign frame_tick = r_frame_tick;
    assign pending    = r_pending;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a multi-digit common-anode 7-segment display.
- Successor to the single-digit combinational BCD-to-7-segment decoder. Adds:
  - digit scanning with a refresh prescaler
  - anti-ghosting guard interval
  - hex/decimal mode and leading-zero blanking
  - per-digit decimal points
  - tear-free, frame-synchronised value update through a pending/shadow register pair
- Sits between the datapath (BCD/hex value producer) and the board display pins.

Parameters:
DIGITS, 4, number of digits; value width is 4*DIGITS.
REFRESH_DIV, 50000, clock cycles per digit slot; must be >= GUARD+2.
GUARD, 2, cycles at the start of each slot with all anodes off; 0 allowed.
SEG_ACTIVE_LOW, 1, 1: seg/dp pins are driven low to light a segment.
AN_ACTIVE_LOW, 1, 1: anode pins are driven low to enable a digit.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value  in  4*DIGITS  digit nibbles; nibble i = value[4i+3:4i]; digit 0 = rightmost
dp_in  in  DIGITS  decimal point request per digit, 1 = lit
load  in  1  single-cycle strobe; captures value/dp_in into pending
hex_mode  in  1  1: nibbles A-F shown as A,b,C,d,E,F; 0: nibbles >9 blanked
lzb_en  in  1  leading-zero blanking enable
blank  in  1  forces all segments and dp off; scanning continues
seg  out  7  segments a..g, seg[0]=a, seg[6]=g, registered
dp  out  1  decimal point, registered
an  out  DIGITS  one-hot (in active polarity) anode enables, registered
digit_idx  out  clog2(DIGITS), min 1  index of the slot currently scanned
frame_tick  out  1  one-cycle pulse at each frame boundary
pending  out  1  1 while a loaded value awaits transfer to the display

Behaviour:
- Reset (async, rst_n=0):
  - prescaler p=0, digit_idx=0
  - shadow and pending registers = 0, pending=0
  - frame_tick=0
  - an = all inactive; seg and dp = all off (inactive polarity)
- Prescaler:
  - p counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_idx increments modulo DIGITS.
- Frame boundary = cycle with digit_idx=DIGITS-1 and p=REFRESH_DIV-1. On that cycle:
  - frame_tick=1 on the next cycle (registered).
  - If pending=1: shadow <= pending regs and pending <= 0.
- Load rules:
  - load captures value/dp_in into the pending regs and sets pending=1.
  - A second load while pending=1 overwrites the pending regs (last wins).
  - A load on the frame-boundary cycle: the old pending contents go to shadow; the new data goes to pending, and pending stays 1.
  - shadow never changes mid-frame.
- Outputs have 1-cycle latency from (p, digit_idx, shadow, mode inputs):
  - Guard interval (p < GUARD): an all inactive.
  - Otherwise: an active for digit_idx only.
  - seg/dp always show the digit_idx nibble (visible only when its anode is on).
- Decode (active-high, pattern g..a):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F
  - A:77 b:7C C:39 d:5E E:79 F:71
  - hex_mode=0 and nibble >9: seg all off.
- Leading-zero blanking (lzb_en=1):
  - Digit i (i >= 1) is blanked when nibbles DIGITS-1..i of shadow are all 0.
  - Digit 0 is never blanked.
  - dp is still shown on LZB-blanked digits.
- blank=1: seg and dp off; an still scans.
- Polarity: final pins are XORed per SEG_ACTIVE_LOW / AN_ACTIVE_LOW.
- Mode input changes (hex_mode, lzb_en, blank) take effect on the next output register update (not frame-synchronised).
- Reset mid-scan returns immediately to the reset state and clears pending.

Test Plan:
All scenarios use DIGITS=4, REFRESH_DIV=8, GUARD=2, both active-low.
1. Reset release, no load:
   - Every slot shows seg=7'b1000000 (digit 0 pattern inverted); an low only for p in 2..7 of each slot.
   - an=4'b1111 during the guard cycles.
   - frame_tick every 32 cycles.
2. load value=16'h12A9, dp_in=4'b0100, hex_mode=1, mid-frame:
   - Display stays 0000 until the next frame_tick.
   - Then the digit 3..0 slots show 1, 2, A, 9 (seg = ~06, ~5B, ~77, ~6F).
   - dp lit only in the digit 2 slot.
   - pending goes 1 then 0.
3. Same value with hex_mode=0 -> digit 1 slot seg=7'b1111111; other digits unchanged.
4. value=16'h0050, lzb_en=1:
   - Digits 3 and 2 are blank (seg all 1); digits 1 and 0 show 5 and 0.
   - value=16'h0000 -> only digit 0 lit, showing 0.
5. Two loads in one frame (16'h1111 then 16'h2222), plus a load of 16'h3333 exactly on the boundary cycle:
   - Next frame shows 2222.
   - The following frame shows 3333.
6. rst_n asserted mid-slot with pending=1:
   - an=4'b1111, seg=7'b1111111, dp=1 asynchronously.
   - pending=0, digit_idx=0.
   - After release the display shows 0000.
